// File: rtl/ej9_sweep_checker.sv
// ej9_sweep_checker: drives {A,B,C,D,E} through every code and compares canonical against reduced outputs.
// Optional build macro STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module ej9_sweep_checker #(
   parameter int K      = 5,
   parameter int NF     = 4,
   parameter int SETTLE = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic [K-1:0]  vec,
   input  logic [NF-1:0] f_ref,
   input  logic [NF-1:0] f_red,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [K:0]    err_count,
   output logic [K-1:0]  first_fail_vec,
   output logic [NF-1:0] first_fail_mask,
   output logic [NF-1:0] fail_mask
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

   localparam logic [K-1:0] VEC_LAST    = '1;
   localparam logic [3:0]   SETTLE_LAST = 4'(SETTLE - 1);

   state_t        state, state_nxt;
   logic [3:0]    settle_cnt;
   logic [NF-1:0] d;
   logic          mis, last, stop, clr, chk, fin;

   assign d    = f_ref ^ f_red;
   assign mis  = (d != '0);
   assign last = (vec == VEC_LAST);

`ifdef STOP_ON_FAIL_EN
   assign stop = mis;
`else
   assign stop = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: if (start) state_nxt = S_WAIT;
         S_WAIT:         if (settle_cnt == SETTLE_LAST) state_nxt = S_CHECK;
         S_CHECK:        state_nxt = (last || stop) ? S_DONE : S_WAIT;
         default:        state_nxt = S_IDLE;
      endcase
   end

   // pass is derived from the held statistics so it can never be high outside DONE
   always_comb begin
      busy = (state == S_WAIT) || (state == S_CHECK);
      done = (state == S_DONE);
      pass = done && (err_count == '0);
      clr  = ((state == S_IDLE) || (state == S_DONE)) && start;
      chk  = (state == S_CHECK);
      fin  = chk && (last || stop);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         vec             <= '0;
         settle_cnt      <= '0;
         err_count       <= '0;
         first_fail_vec  <= '0;
         first_fail_mask <= '0;
         fail_mask       <= '0;
      end else if (clr) begin
         vec             <= '0;
         settle_cnt      <= '0;
         err_count       <= '0;
         first_fail_vec  <= '0;
         first_fail_mask <= '0;
         fail_mask       <= '0;
      end else if (state == S_WAIT) begin
         settle_cnt <= settle_cnt + 4'd1;
      end else if (chk) begin
         if (mis) begin
            err_count <= err_count + (K+1)'(1);
            fail_mask <= fail_mask | d;
            if (err_count == '0) begin
               first_fail_vec  <= vec;
               first_fail_mask <= d;
            end
         end
         if (!fin) begin
            vec        <= vec + K'(1);
            settle_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_ej9_sweep_checker.sv
// Bench for ej9_sweep_checker: table-driven fault patterns, random fault maps checked
// against a per-vector reference model, plus reset and restart sequences.
module tb_ej9_sweep_checker;
   localparam int K  = 5;
   localparam int NF = 4;
   localparam int S  = 1;
   localparam int NV = 1 << K;
`ifdef STOP_ON_FAIL_EN
   localparam bit STOP = 1'b1;
`else
   localparam bit STOP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset, start;
   logic [K-1:0]  vec;
   logic [NF-1:0] f_ref, f_red;
   logic          busy, done, pass;
   logic [K:0]    err_count;
   logic [K-1:0]  first_fail_vec;
   logic [NF-1:0] first_fail_mask, fail_mask;

   logic [NF-1:0] fault_tbl [NV];
   int checks = 0;
   int errors = 0;

   ej9_sweep_checker #(.K(K), .NF(NF), .SETTLE(S)) dut (
      .clk(clk), .reset(reset), .start(start), .vec(vec),
      .f_ref(f_ref), .f_red(f_red), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .first_fail_vec(first_fail_vec),
      .first_fail_mask(first_fail_mask), .fail_mask(fail_mask)
   );

   always #5 clk = ~clk;

   // Stand-in for the combinational block: arbitrary canonical function, reduced = canonical ^ fault
   always_comb begin
      f_ref = 4'((vec * 5'd7) + 5'd3);
      f_red = f_ref ^ fault_tbl[vec];
   end

   typedef struct {
      int va; int ma; int vb; int mb; int all_m;
      int e_err; int e_ffv; int e_ffm; int e_fm; int e_pass; int e_lat; int e_vec;
   } rec_t;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic clear_faults();
      for (int i = 0; i < NV; i++) fault_tbl[i] = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: walk every vector in order and accumulate the statistics directly
   task automatic model(output int e_err, output int e_ffv, output int e_ffm, output int e_fm,
                        output int e_pass, output int e_lat, output int e_vec);
      e_err = 0; e_ffv = 0; e_ffm = 0; e_fm = 0; e_vec = NV - 1;
      for (int i = 0; i < NV; i++) begin
         if (fault_tbl[i] != 0) begin
            if (e_err == 0) begin
               e_ffv = i;
               e_ffm = int'(fault_tbl[i]);
            end
            e_err++;
            e_fm = e_fm | int'(fault_tbl[i]);
            if (STOP) begin
               e_vec = i;
               break;
            end
         end
      end
      e_lat  = (e_vec + 1) * (S + 1);
      e_pass = (e_err == 0) ? 1 : 0;
   endtask

   // Pulse start, follow the sweep edge by edge, then compare the final statistics.
   // n counts edges after the edge that sampled start.
   task automatic run_and_check(input string nm, input int repulse, input int e_err, input int e_ffv,
                                input int e_ffm, input int e_fm, input int e_pass, input int e_lat,
                                input int e_vec);
      int  n, exp_v, clr_err, clr_fm;
      bit  trace_ok, pulsed;
      trace_ok = 1'b1;
      pulsed   = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      clr_err = int'(err_count);
      clr_fm  = int'(fail_mask);
      forever begin
         exp_v = n / (S + 1);
         if (exp_v > e_vec) exp_v = e_vec;
         if (int'(vec) != exp_v || busy !== (n < e_lat) || done !== (n >= e_lat) ||
             (busy && done) || (!done && pass))
            trace_ok = 1'b0;
         if (done || n > 4 * NV * (S + 1)) break;
         if (repulse >= 0 && !pulsed && int'(vec) == repulse) begin
            start  = 1'b1;
            pulsed = 1'b1;
         end else begin
            start = 1'b0;
         end
         tick();
         n++;
      end
      start = 1'b0;
      chk({nm, " latency"},      n, e_lat);
      chk({nm, " trace"},        int'(trace_ok), 1);
      chk({nm, " cleared_err"},  clr_err, 0);
      chk({nm, " cleared_mask"}, clr_fm, 0);
      chk({nm, " vec"},          int'(vec), e_vec);
      chk({nm, " pass"},         int'(pass), e_pass);
      chk({nm, " err_count"},    int'(err_count), e_err);
      chk({nm, " first_vec"},    int'(first_fail_vec), e_ffv);
      chk({nm, " first_mask"},   int'(first_fail_mask), e_ffm);
      chk({nm, " fail_mask"},    int'(fail_mask), e_fm);
      chk({nm, " busy_low"},     int'(busy), 0);
   endtask

   task automatic check_idle(input string nm);
      chk({nm, " vec"},        int'(vec), 0);
      chk({nm, " busy"},       int'(busy), 0);
      chk({nm, " done"},       int'(done), 0);
      chk({nm, " pass"},       int'(pass), 0);
      chk({nm, " err_count"},  int'(err_count), 0);
      chk({nm, " first_vec"},  int'(first_fail_vec), 0);
      chk({nm, " first_mask"}, int'(first_fail_mask), 0);
      chk({nm, " fail_mask"},  int'(fail_mask), 0);
   endtask

   rec_t tbl [5];

   initial begin
      int m_err, m_ffv, m_ffm, m_fm, m_pass, m_lat, m_vec, n;
      bit found;

      //      va  ma   vb  mb   all   err ffv ffm  fm  pass lat vec
      tbl[0] = '{-1, 0,  -1, 0,   0,     0,  0,  0,   0,  1,  64, 31};
`ifdef STOP_ON_FAIL_EN
      tbl[1] = '{ 5, 4,  -1, 0,   0,     1,  5,  4,   4,  0,  12,  5};
      tbl[2] = '{31, 8,  -1, 0,   1,     1,  0,  1,   1,  0,   2,  0};
      tbl[3] = '{31, 15, -1, 0,   0,     1, 31, 15,  15,  0,  64, 31};
      tbl[4] = '{ 0, 2,  17, 3,   0,     1,  0,  2,   2,  0,   2,  0};
`else
      tbl[1] = '{ 5, 4,  -1, 0,   0,     1,  5,  4,   4,  0,  64, 31};
      tbl[2] = '{31, 8,  -1, 0,   1,    32,  0,  1,   9,  0,  64, 31};
      tbl[3] = '{31, 15, -1, 0,   0,     1, 31, 15,  15,  0,  64, 31};
      tbl[4] = '{ 0, 2,  17, 3,   0,     2,  0,  2,   3,  0,  64, 31};
`endif

      clear_faults();
      reset = 1'b0;
      start = 1'b1;
      tick();
      tick();
      check_idle("reset");
      start = 1'b0;
      reset = 1'b1;
      tick();
      check_idle("idle_hold");

      foreach (tbl[t]) begin
         clear_faults();
         for (int i = 0; i < NV; i++) fault_tbl[i] = 4'(tbl[t].all_m);
         if (tbl[t].va >= 0) fault_tbl[tbl[t].va] = fault_tbl[tbl[t].va] | 4'(tbl[t].ma);
         if (tbl[t].vb >= 0) fault_tbl[tbl[t].vb] = fault_tbl[tbl[t].vb] | 4'(tbl[t].mb);
         run_and_check($sformatf("tbl%0d", t), -1, tbl[t].e_err, tbl[t].e_ffv, tbl[t].e_ffm,
                       tbl[t].e_fm, tbl[t].e_pass, tbl[t].e_lat, tbl[t].e_vec);
      end

      for (int r = 0; r < 6; r++) begin
         clear_faults();
         for (int i = 0; i < NV; i++)
            if (r != 0 && $urandom_range(0, 5) == 0) fault_tbl[i] = 4'($urandom);
         model(m_err, m_ffv, m_ffm, m_fm, m_pass, m_lat, m_vec);
         run_and_check($sformatf("rand%0d", r), -1, m_err, m_ffv, m_ffm, m_fm, m_pass, m_lat, m_vec);
      end

      // Reset in the middle of a faulty sweep, then a clean full sweep
      clear_faults();
      fault_tbl[5] = 4'b0100;
      start = 1'b1;
      tick();
      start = 1'b0;
      found = 1'b0;
      n = 0;
      while (!found && n < 200) begin
         if (vec == 5'd12) found = 1'b1;
         else begin
            tick();
            n++;
         end
      end
      chk("midreset reached_vec12", int'(found), 1);
      chk("midreset stats_before", int'(err_count), 1);
      reset = 1'b0;
      tick();
      check_idle("midreset");
      reset = 1'b1;
      tick();
      check_idle("midreset_idle");
      clear_faults();
      run_and_check("after_reset", -1, 0, 0, 0, 0, 1, 64, 31);

      // start while busy is ignored; then restart from DONE after a faulty sweep
      run_and_check("repulse", 3, 0, 0, 0, 0, 1, 64, 31);
      fault_tbl[9] = 4'b0011;
      model(m_err, m_ffv, m_ffm, m_fm, m_pass, m_lat, m_vec);
      run_and_check("faulty", -1, m_err, m_ffv, m_ffm, m_fm, m_pass, m_lat, m_vec);
      clear_faults();
      run_and_check("restart_done", -1, 0, 0, 0, 0, 1, 64, 31);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
